// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side stream stage: default width, skid-buffer
// occupancy encodings and the width used for read-credit arithmetic.
package fifo_rd_stream_pkg;

   localparam int unsigned DATA_W_DEF = 32;

   // Holds 2 + pop (max 3) and level + inflight (max 3) without wrap.
   localparam int unsigned CREDIT_W = 3;

   typedef enum logic [1:0] {
      LVL_EMPTY = 2'd0,
      LVL_ONE   = 2'd1,
      LVL_TWO   = 2'd2
   } lvl_e;

endpackage

// File: rtl/fifo_rd_stream_skid2.sv
// Two-entry skid buffer with a push/pop interface; e0 is always the head of the stream.
module fifo_rd_stream_skid2
   import fifo_rd_stream_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic [1:0]        o_level
);

   lvl_e              state_q, state_d;
   logic [DATA_W-1:0] e0_q, e0_d;
   logic [DATA_W-1:0] e1_q, e1_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= LVL_EMPTY;
         e0_q    <= '0;
         e1_q    <= '0;
      end else begin
         state_q <= state_d;
         e0_q    <= e0_d;
         e1_q    <= e1_d;
      end
   end

   always_comb begin
      state_d = state_q;
      e0_d    = e0_q;
      e1_d    = e1_q;
      case (state_q)
         LVL_EMPTY: begin
            if (i_push) begin
               state_d = LVL_ONE;
               e0_d    = i_push_data;
            end
         end
         LVL_ONE: begin
            if (i_push && i_pop) begin
               e0_d = i_push_data;
            end else if (i_push) begin
               state_d = LVL_TWO;
               e1_d    = i_push_data;
            end else if (i_pop) begin
               state_d = LVL_EMPTY;
            end
         end
         LVL_TWO: begin
            // Upstream credit guarantees no push here without a matching pop.
            if (i_pop) begin
               e0_d = e1_q;
               if (i_push) begin
                  e1_d = i_push_data;
               end else begin
                  state_d = LVL_ONE;
               end
            end
         end
         default: state_d = LVL_EMPTY;
      endcase
   end

   assign o_valid = (state_q != LVL_EMPTY);
   assign o_data  = e0_q;
   assign o_level = state_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the FIFO read port into a valid/ready stream; reads are issued only against
// free skid-buffer slots, so one word per cycle is sustained without overflow.
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_fifo_empty,
   output logic              o_fifo_rd,
   input  logic [DATA_W-1:0] i_fifo_rdata,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [1:0]        o_level,
   output logic [CNT_W-1:0]  o_words
);

   logic                inflight_q;
   logic                pop;
   logic [CREDIT_W-1:0] credit_avail;
   logic [CREDIT_W-1:0] credit_used;
   logic [CNT_W-1:0]    words_q;

   assign pop = o_valid && i_ready;

   // credit = 2 - level - inflight + pop, evaluated as a compare to stay unsigned.
   assign credit_avail = CREDIT_W'(2) + CREDIT_W'(pop);
   assign credit_used  = CREDIT_W'(o_level) + CREDIT_W'(inflight_q);
   assign o_fifo_rd    = !i_rst && !i_fifo_empty && (credit_avail > credit_used);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         inflight_q <= 1'b0;
         words_q    <= '0;
      end else begin
         inflight_q <= o_fifo_rd;
         if (pop) begin
            words_q <= words_q + CNT_W'(1);
         end
      end
   end

   assign o_words = words_q;

   fifo_rd_stream_skid2 #(
      .DATA_W (DATA_W)
   ) u_skid (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (inflight_q),
      .i_push_data (i_fifo_rdata),
      .i_pop       (pop),
      .o_valid     (o_valid),
      .o_data      (o_data),
      .o_level     (o_level)
   );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a behavioural FIFO read port feeds the DUT and a
// scoreboard checks stream order; CNT_W is reduced so the word counter wraps quickly.
module tb_fifo_rd_stream;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 5;

   logic              clk;
   logic              i_rst;
   logic              fifo_empty;
   logic              fifo_rd;
   logic [DATA_W-1:0] fifo_rdata;
   logic              o_valid;
   logic              i_ready;
   logic [DATA_W-1:0] o_data;
   logic [1:0]        o_level;
   logic [CNT_W-1:0]  o_words;

   logic [31:0] mem [0:255];
   int          wr_ptr;
   int          rd_ptr;
   logic [31:0] exp_q [$];
   int          n_checks;
   int          n_errors;

   fifo_rd_stream #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_fifo_empty (fifo_empty),
      .o_fifo_rd    (fifo_rd),
      .i_fifo_rdata (fifo_rdata),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_data       (o_data),
      .o_level      (o_level),
      .o_words      (o_words)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO read port model: registered data, junk when no read so stray sampling shows up.
   assign fifo_empty = (rd_ptr == wr_ptr);
   always @(posedge clk) begin
      if (fifo_rd) begin
         fifo_rdata <= mem[rd_ptr];
         rd_ptr     <= rd_ptr + 1;
      end else begin
         fifo_rdata <= 32'hDEAD_BEEF;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] d);
      mem[wr_ptr] = d;
      wr_ptr      = wr_ptr + 1;
      exp_q.push_back(d);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag, input int max);
      bit done;
      done = 1'b0;
      for (int k = 0; k < max; k++) begin
         cyc();
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && !o_valid) begin
            done = 1'b1;
            break;
         end
      end
      check(tag, 32'(done), 32'd1);
   endtask

   // Stream scoreboard and per-cycle invariants.
   always @(negedge clk) begin
      if (!i_rst) begin
         check("level_le2", 32'(o_level <= 2'd2), 32'd1);
         if (fifo_empty) check("rd_when_empty", 32'(fifo_rd), 32'd0);
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $error("FAIL unexpected_word: observed=%0h expected=none", o_data);
            end else begin
               check("stream_data", o_data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n;
      int rd0;
      bit done;
      wr_ptr   = 0;
      rd_ptr   = 0;
      n_checks = 0;
      n_errors = 0;
      i_rst    = 1'b1;
      i_ready  = 1'b0;

      // Reset values
      repeat (2) cyc();
      @(negedge clk);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_data", o_data, 32'd0);
      check("rst_level", 32'(o_level), 32'd0);
      check("rst_words", 32'(o_words), 32'd0);
      check("rst_rd", 32'(fifo_rd), 32'd0);
      cyc();
      i_rst   = 1'b0;
      i_ready = 1'b1;

      // Four words, consumer always ready: o_valid at N+2, then back-to-back
      cyc();
      for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
      @(negedge clk);
      check("lat_rd_n", 32'(fifo_rd), 32'd1);
      check("lat_valid_n", 32'(o_valid), 32'd0);
      cyc();
      @(negedge clk);
      check("lat_valid_n1", 32'(o_valid), 32'd0);
      check("lat_rd_n1", 32'(fifo_rd), 32'd1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         @(negedge clk);
         check("burst_valid", 32'(o_valid), 32'd1);
         check("burst_data", o_data, 32'hA0 + 32'(i));
      end
      cyc();
      @(negedge clk);
      check("burst_end_valid", 32'(o_valid), 32'd0);
      check("burst_words", 32'(o_words), 32'd4);

      // Backpressure: exactly two reads, head stable, then a back-to-back drain
      cyc();
      i_ready = 1'b0;
      cyc();
      rd0 = rd_ptr;
      for (int i = 0; i < 8; i++) push_word(32'hB0 + 32'(i));
      repeat (6) cyc();
      @(negedge clk);
      check("bp_reads", 32'(rd_ptr - rd0), 32'd2);
      check("bp_level", 32'(o_level), 32'd2);
      check("bp_data", o_data, 32'hB0);
      repeat (3) cyc();
      @(negedge clk);
      check("bp_hold_data", o_data, 32'hB0);
      check("bp_hold_reads", 32'(rd_ptr - rd0), 32'd2);
      cyc();
      i_ready = 1'b1;
      n = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (!o_valid) break;
         n++;
         cyc();
      end
      check("bp_b2b_count", 32'(n), 32'd8);
      check("bp_all_out", 32'(exp_q.size()), 32'd0);
      check("bp_words", 32'(o_words), 32'd12);

      // Alternating ready over 16 words
      cyc();
      for (int i = 0; i < 16; i++) push_word(32'hC0 + 32'(i));
      done = 1'b0;
      for (int k = 0; k < 100; k++) begin
         cyc();
         i_ready = ~i_ready;
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && !o_valid) begin
            done = 1'b1;
            break;
         end
      end
      check("alt_drained", 32'(done), 32'd1);
      check("alt_words", 32'(o_words), 32'd28);

      // Reset while full: buffered words discarded, next word is the next FIFO entry
      cyc();
      i_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_word(32'hD0 + 32'(i));
      repeat (6) cyc();
      @(negedge clk);
      check("pre_rst_level", 32'(o_level), 32'd2);
      check("pre_rst_data", o_data, 32'hD0);
      cyc();
      i_rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(o_valid), 32'd0);
      check("mid_rst_data", o_data, 32'd0);
      check("mid_rst_level", 32'(o_level), 32'd0);
      check("mid_rst_words", 32'(o_words), 32'd0);
      check("mid_rst_rd", 32'(fifo_rd), 32'd0);
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      cyc();
      i_rst   = 1'b0;
      i_ready = 1'b1;
      drain("rst_drain", 20);
      check("rst_words_after", 32'(o_words), 32'd2);

      // Counter wrap (CNT_W = 5): 2 + 28 = 30, then two more pops wrap to 0
      for (int i = 0; i < 28; i++) push_word(32'hE000 + 32'(i));
      drain("wrap_drain1", 80);
      check("wrap_words30", 32'(o_words), 32'd30);
      push_word(32'hF000);
      push_word(32'hF001);
      drain("wrap_drain2", 20);
      check("wrap_words0", 32'(o_words), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
